// File: rtl/fp_pkg.sv
// Shared types and field helpers for the parametrised floating-point add/sub datapath.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

    function automatic int unsigned exp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned exp_ones(input int unsigned exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

    // Canonical quiet NaN: positive sign, all-ones exponent, fraction MSB set
    function automatic logic [63:0] qnan_word(input int unsigned exp_w, input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 32'd1));
    endfunction

    function automatic logic [63:0] fld_frac(input logic [63:0] w, input int unsigned man_w);
        return w & ((64'd1 << man_w) - 64'd1);
    endfunction

    function automatic logic [63:0] fld_exp(input logic [63:0] w, input int unsigned exp_w,
                                            input int unsigned man_w);
        return (w >> man_w) & ((64'd1 << exp_w) - 64'd1);
    endfunction

    function automatic logic fld_sign(input logic [63:0] w, input int unsigned exp_w,
                                      input int unsigned man_w);
        return 1'(w >> (exp_w + man_w));
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a {hidden, frac, G, R, S} mantissa with exponent adjust and overflow clamp.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [MAN_W+3:0] man,
    input  logic [EXP_W:0]   exp_in,
    output logic [MAN_W-1:0] frac_c,
    output logic [EXP_W-1:0] exp_c,
    output logic             ovf_c
);
    localparam int unsigned EW = EXP_W + 1;
    localparam int unsigned SW = MAN_W + 2;
    localparam logic [EW-1:0] EXP_MAX = EW'(exp_ones(EXP_W));

    logic           inc;
    logic [SW-1:0]  sum;
    logic [EW-1:0]  exp_adj;
    logic [MAN_W-1:0] frac_n;

    always_comb begin
        inc = man[2] && (man[1] || man[0] || man[3]);
        sum = {1'b0, man[MAN_W+3:3]} + SW'(inc);
        // Rounding carried into a new integer bit: renormalise by one
        if (sum[SW-1]) begin
            frac_n  = sum[MAN_W:1];
            exp_adj = exp_in + EW'(1);
        end else begin
            frac_n  = sum[MAN_W-1:0];
            exp_adj = exp_in;
        end
        ovf_c  = (exp_adj >= EXP_MAX);
        exp_c  = ovf_c ? EXP_W'(EXP_MAX) : EXP_W'(exp_adj);
        frac_c = ovf_c ? '0 : frac_n;
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754-style add/subtract: align, add, one-bit-per-cycle normalise, RNE round.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned N     = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         overflow
);
    localparam int unsigned DW = MAN_W + 4;
    localparam int unsigned EW = EXP_W + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_ones(EXP_W));
    localparam logic [N-1:0]     QNAN     = N'(qnan_word(EXP_W, MAN_W));

    state_t state, next_state;

    logic [N-1:0]  a_q, b_q;
    logic          op_q;
    logic          sign_q, eff_sub_q, zero_q, ovf_q;
    logic [EW-1:0] exp_q;
    logic [DW-1:0] x_man_q, y_man_q, man_q;
    logic [N-1:0]  pack_q;

    logic [EXP_W-1:0] ea, eb, x_e, y_e, d;
    logic [MAN_W-1:0] fa, fb;
    logic             sa, sb, x_s, swap;
    logic             a_zero, b_zero, a_inf, b_inf, any_nan, special;
    logic [N-1:0]     spec_word;
    logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
    logic [DW-1:0]    ma, mb, x_m, y_m, y_al;

    // Operand decode and alignment; b's sign already reflects op
    always_comb begin
        ea = EXP_W'(fld_exp(64'(a_q), EXP_W, MAN_W));
        eb = EXP_W'(fld_exp(64'(b_q), EXP_W, MAN_W));
        fa = MAN_W'(fld_frac(64'(a_q), MAN_W));
        fb = MAN_W'(fld_frac(64'(b_q), MAN_W));
        sa = fld_sign(64'(a_q), EXP_W, MAN_W);
        sb = fld_sign(64'(b_q), EXP_W, MAN_W) ^ op_q;

        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        a_inf   = (ea == EXP_ONES) && (fa == '0);
        b_inf   = (eb == EXP_ONES) && (fb == '0);
        any_nan = ((ea == EXP_ONES) && (fa != '0)) || ((eb == EXP_ONES) && (fb != '0));
        special = any_nan || a_inf || b_inf || (a_zero && b_zero);

        if (any_nan || (a_inf && b_inf && (sa != sb)))
            spec_word = QNAN;
        else if (a_inf)
            spec_word = {sa, EXP_ONES, {MAN_W{1'b0}}};
        else if (b_inf)
            spec_word = {sb, EXP_ONES, {MAN_W{1'b0}}};
        else
            spec_word = {sa & sb, {(N-1){1'b0}}};

        ma    = a_zero ? '0 : {1'b1, fa, 3'b000};
        mb    = b_zero ? '0 : {1'b1, fb, 3'b000};
        mag_a = a_zero ? '0 : {ea, fa};
        mag_b = b_zero ? '0 : {eb, fb};
        swap  = (mag_b > mag_a);
        x_s   = swap ? sb : sa;
        x_e   = swap ? eb : ea;
        y_e   = swap ? ea : eb;
        x_m   = swap ? mb : ma;
        y_m   = swap ? ma : mb;
        d     = x_e - y_e;

        if (32'(d) >= DW - 1)
            y_al = {{(DW-1){1'b0}}, |y_m};
        else
            y_al = (y_m >> d) | DW'(|(y_m & ~({DW{1'b1}} << d)));
    end

    logic [DW:0]   sum;
    logic          carry, sum_zero, add_to_norm;
    logic [DW-1:0] norm_man;
    logic          norm_done;

    // Magnitude add/subtract and the single-step normaliser
    always_comb begin
        sum         = eff_sub_q ? ({1'b0, x_man_q} - {1'b0, y_man_q})
                                : ({1'b0, x_man_q} + {1'b0, y_man_q});
        carry       = sum[DW];
        sum_zero    = (sum == '0);
        add_to_norm = !carry && !sum_zero && !sum[DW-1] && (exp_q > EW'(1));
        norm_man    = {man_q[DW-2:0], 1'b0};
        norm_done   = norm_man[DW-1] || (exp_q == EW'(2));
    end

    logic [MAN_W-1:0] r_frac;
    logic [EXP_W-1:0] r_exp;
    logic             r_ovf;

    fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .man    (man_q),
        .exp_in (exp_q),
        .frac_c (r_frac),
        .exp_c  (r_exp),
        .ovf_c  (r_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid && in_ready) next_state = ALIGN;
            ALIGN:   next_state = special ? DONE : ADD;
            ADD:     next_state = add_to_norm ? NORM : ROUND;
            NORM:    if (norm_done) next_state = ROUND;
            ROUND:   next_state = DONE;
            DONE:    if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            exp_q     <= '0;
            x_man_q   <= '0;
            y_man_q   <= '0;
            man_q     <= '0;
            pack_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op;
                    end
                end
                ALIGN: begin
                    sign_q    <= x_s;
                    exp_q     <= {1'b0, x_e};
                    x_man_q   <= x_m;
                    y_man_q   <= y_al;
                    eff_sub_q <= sa ^ sb;
                    zero_q    <= 1'b0;
                    pack_q    <= spec_word;
                    ovf_q     <= 1'b0;
                end
                ADD: begin
                    if (carry) begin
                        man_q <= {sum[DW:2], sum[1] | sum[0]};
                        exp_q <= exp_q + EW'(1);
                    end else begin
                        man_q <= sum[DW-1:0];
                        // Exact cancellation, or an unnormalised result with no exponent left
                        if (sum_zero || (!sum[DW-1] && (exp_q <= EW'(1))))
                            zero_q <= 1'b1;
                    end
                end
                NORM: begin
                    man_q <= norm_man;
                    exp_q <= exp_q - EW'(1);
                    if (!norm_man[DW-1] && (exp_q == EW'(2)))
                        zero_q <= 1'b1;
                end
                ROUND: begin
                    if (zero_q) begin
                        pack_q <= '0;
                        ovf_q  <= 1'b0;
                    end else begin
                        pack_q <= {sign_q, r_exp, r_frac};
                        ovf_q  <= r_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs; result loads on the first DONE cycle and holds until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            in_ready <= (next_state == IDLE);
            if ((state == DONE) && !out_valid) begin
                out_valid <= 1'b1;
                result    <= pack_q;
                overflow  <= ovf_q;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
